ir_encoder: RTL and testbench
=============================

Name: ir_encoder

Overview:
- IR transmitter counterpart to the IR receive path.
- Serialises a 32-bit code into the pulse-distance frame the decoder expects. Frame: sync burst, sync silence, 32 data bits each sent as burst + silence, then a stop burst.
- Drives an active-low envelope (signal_out) that loops directly into the decoder's signal_in.
- Also drives an active-high, carrier-modulated LED output (ir_out) for the IR emitter pin.

Parameters:
- SBD, 900_000, sync burst duration in cycles.
- SSD, 450_000, sync silence duration in cycles.
- BBD, 60_000, bit burst and stop burst duration in cycles.
- BSD0, 60_000, silence duration in cycles for a '0'.
- BSD1, 160_000, silence duration in cycles for a '1'.
- GAP, 200_000, minimum idle-high time after the stop burst before the next frame.
- CARRIER_PERIOD, 2632, carrier period in cycles (38 kHz at 100 MHz); must be even and ≥2.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  reset, asynchronous, active-low.
- code_in  input  32  code to transmit; sampled only on the accept cycle.
- send_in  input  1  request to transmit; accepted only when busy_out=0.
- busy_out  output  1  high from the cycle after accept through the end of GAP.
- done_out  output  1  single-cycle pulse when the stop burst ends.
- signal_out  output  1  envelope: 0 = burst, 1 = silence/idle.
- ir_out  output  1  carrier-modulated LED drive; 0 whenever signal_out=1.
- state_out  output  4  current FSM state, for debug.

Behaviour:
- Reset (rst_in=0, asynchronous), all effective immediately:
  - state=IDLE, busy_out=0, done_out=0, signal_out=1, ir_out=0.
  - Shift register, bit counter, duration counter and carrier counter all cleared.
- Reset mid-frame aborts the frame immediately. No done_out pulse is produced.
- States and encodings: IDLE=0, SYNC_B=1, SYNC_S=2, BIT_B=3, BIT_S=4, STOP_B=5, GAP_W=6.
- Accept:
  - Condition: state=IDLE and send_in=1 on a rising edge (cycle T).
  - At T, latch code_in into the shift register and enter SYNC_B.
  - From T+1: busy_out=1 and signal_out=0.
  - send_in while busy is ignored; no queueing.
- Segment durations (one duration counter, cleared on each state entry; a state of length D holds signal_out constant for exactly D cycles):
  - SYNC_B: D=SBD, signal_out=0, then SYNC_S.
  - SYNC_S: D=SSD, signal_out=1, then BIT_B.
  - BIT_B: D=BBD, signal_out=0, then BIT_S.
  - BIT_S: D=BSD1 if current MSB=1, else BSD0; signal_out=1.
    - On exit: shift the register left by 1 and increment the bit counter.
    - Go to BIT_B if the bit counter is now < 32; go to STOP_B after the 32nd bit.
  - STOP_B: D=BBD, signal_out=0. The stop burst terminates the 32nd silence so the decoder can measure it.
  - On STOP_B exit: done_out=1 for exactly one cycle (the first cycle of GAP_W).
  - GAP_W: D=GAP, signal_out=1, busy_out=1; then IDLE with busy_out=0. A new send may be accepted on that cycle.
- Bit order is MSB first (code_in[31] sent first), so the decoder's left-shift reconstructs the identical word.
- Frame length from T+1 to STOP_B end: SBD + SSD + 33·BBD + n1·BSD1 + (32−n1)·BSD0 cycles, where n1 = number of ones in the code.
- Carrier:
  - The carrier counter resets to 0 on entry to every burst state.
  - ir_out=1 while the counter < CARRIER_PERIOD/2 and signal_out=0; the counter wraps at CARRIER_PERIOD−1.
  - ir_out=0 in all silence, gap and idle states.
- All outputs are registered. No combinational path from inputs to outputs.
- Counter widths must hold max(SBD, SSD, BSD1, GAP); 32-bit counters are acceptable.

Test Plan (scaled parameters: SBD=90, SSD=45, BBD=6, BSD0=6, BSD1=16, GAP=20, CARRIER_PERIOD=4):
- Reset, then idle 50 cycles -> signal_out=1, ir_out=0, busy_out=0, done_out=0 throughout.
- send_in pulse with code_in=0xA5A50F0F (n1=16) -> signal_out low from T+1 for exactly 90 cycles, then high for 45. Burst/silence widths follow 1,0,1,0,0,1,0,1,… MSB first. done_out pulses exactly once, 685 cycles after T+1. busy_out drops 20 cycles later.
- Loopback of signal_out into ir_decoder (same scaled timings, MARGIN=2), codes 0x00000000, 0xFFFFFFFF and 0xA5A50F0F -> one new_code_out per frame, with code_out equal to the sent code.
- Carrier check during the sync burst -> ir_out toggles 1,1,0,0 repeating for 90 cycles; ir_out=0 in every silence.
- send_in held high continuously with code changing mid-frame -> the latched code is sent unchanged. The next frame starts on the cycle busy_out drops, using the code_in value present at that cycle.
- rst_in asserted low during BIT_S of bit 10 -> signal_out=1 and ir_out=0 asynchronously, no done_out pulse. After release, a new send produces a complete, correct frame.

Source files
------------

// File: rtl/ir_encoder.sv
// IR pulse-distance transmitter: sync burst/silence, 32 MSB-first data bits
// (burst + length-coded silence), stop burst, then an idle gap.
// signal_out is the active-low envelope; ir_out is the carrier-gated LED drive.
module ir_encoder #(
    parameter int unsigned SBD            = 900_000,
    parameter int unsigned SSD            = 450_000,
    parameter int unsigned BBD            = 60_000,
    parameter int unsigned BSD0           = 60_000,
    parameter int unsigned BSD1           = 160_000,
    parameter int unsigned GAP            = 200_000,
    parameter int unsigned CARRIER_PERIOD = 2632
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        send_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        signal_out,
    output logic        ir_out,
    output logic [3:0]  state_out
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SYNC_B = 4'd1,
        SYNC_S = 4'd2,
        BIT_B  = 4'd3,
        BIT_S  = 4'd4,
        STOP_B = 4'd5,
        GAP_W  = 4'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] car_q, car_d;
    logic [5:0]  bit_q, bit_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sig_q, sig_d;
    logic        ir_q, ir_d;
    logic [31:0] dur;
    logic        last;

    // Length of the segment currently being emitted
    always_comb begin
        dur = 32'd1;
        case (state_q)
            SYNC_B:        dur = 32'(SBD);
            SYNC_S:        dur = 32'(SSD);
            BIT_B, STOP_B: dur = 32'(BBD);
            BIT_S:         dur = sh_q[31] ? 32'(BSD1) : 32'(BSD0);
            GAP_W:         dur = 32'(GAP);
            default:       dur = 32'd1;
        endcase
        last = (cnt_q == dur - 32'd1);
    end

    // Next-state, envelope and carrier computation; every output is the
    // registered copy of its _d, so nothing combinational reaches a port
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sig_d   = sig_q;
        cnt_d   = cnt_q + 32'd1;
        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (send_in) begin
                    state_d = SYNC_B;
                    sh_d    = code_in;
                    bit_d   = 6'd0;
                    busy_d  = 1'b1;
                    sig_d   = 1'b0;
                end
            end
            SYNC_B: if (last) begin
                state_d = SYNC_S; cnt_d = 32'd0; sig_d = 1'b1;
            end
            SYNC_S: if (last) begin
                state_d = BIT_B; cnt_d = 32'd0; sig_d = 1'b0;
            end
            BIT_B: if (last) begin
                state_d = BIT_S; cnt_d = 32'd0; sig_d = 1'b1;
            end
            BIT_S: if (last) begin
                sh_d    = {sh_q[30:0], 1'b0};
                bit_d   = bit_q + 6'd1;
                state_d = (bit_q == 6'd31) ? STOP_B : BIT_B;
                cnt_d   = 32'd0;
                sig_d   = 1'b0;
            end
            STOP_B: if (last) begin
                state_d = GAP_W; cnt_d = 32'd0; sig_d = 1'b1; done_d = 1'b1;
            end
            GAP_W: if (last) begin
                state_d = IDLE; cnt_d = 32'd0; busy_d = 1'b0;
            end
            default: begin
                state_d = IDLE; cnt_d = 32'd0; busy_d = 1'b0; sig_d = 1'b1;
            end
        endcase

        // Carrier phase restarts at every silence->burst edge so each burst
        // begins with a full high half-period
        if (sig_d)
            car_d = 32'd0;
        else if (sig_q)
            car_d = 32'd0;
        else if (car_q == 32'(CARRIER_PERIOD - 1))
            car_d = 32'd0;
        else
            car_d = car_q + 32'd1;
        ir_d = !sig_d && (car_d < 32'(CARRIER_PERIOD / 2));
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            car_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= 1'b1;
            ir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            car_q   <= car_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
            ir_q    <= ir_d;
        end
    end

    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign signal_out = sig_q;
    assign ir_out     = ir_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_ir_encoder.sv
// Bench for ir_encoder with scaled timings. Expected envelope segments and
// codes are queued when a frame is requested; a negedge monitor measures the
// envelope, decodes it back to a word and pops/compares both queues.
module tb_ir_encoder;

    localparam int SBD = 90, SSD = 45, BBD = 6, BSD0 = 6, BSD1 = 16, GAP = 20, CP = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] code_in = '0;
    logic        send_in = 1'b0;
    logic        busy_out, done_out, signal_out, ir_out;
    logic [3:0]  state_out;

    ir_encoder #(.SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
                 .GAP(GAP), .CARRIER_PERIOD(CP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .code_in(code_in), .send_in(send_in),
        .busy_out(busy_out), .done_out(done_out), .signal_out(signal_out),
        .ir_out(ir_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { bit lvl; int len; } seg_t;
    seg_t        segq[$];
    logic [31:0] codeq[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int ndone = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic void push_frame(input logic [31:0] c);
        seg_t s;
        s.lvl = 1'b0; s.len = SBD; segq.push_back(s);
        s.lvl = 1'b1; s.len = SSD; segq.push_back(s);
        for (int i = 31; i >= 0; i--) begin
            s.lvl = 1'b0; s.len = BBD; segq.push_back(s);
            s.lvl = 1'b1; s.len = c[i] ? BSD1 : BSD0; segq.push_back(s);
        end
        s.lvl = 1'b0; s.len = BBD; segq.push_back(s);
        codeq.push_back(c);
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;

    // Envelope monitor: segment widths, carrier shape, decoded word, done count
    bit          prev = 1'b1;
    int          run = 0;
    int          cerr = 0;
    bit          dec = 1'b0, first_hi = 1'b0;
    int          nb = 0;
    logic [31:0] word = '0;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            prev = 1'b1; run = 0; dec = 1'b0; cerr = 0;
        end else begin
            if (done_out) ndone++;
            if (signal_out == prev) run++;
            else begin
                if (prev == 1'b0) begin
                    if (segq.size() > 0 && segq[0].lvl == 1'b0) begin
                        chk("seg_lo", run, segq[0].len);
                        void'(segq.pop_front());
                    end else chk("seg_lo_extra", 1, 0);
                    if (run == SBD) begin dec = 1'b1; first_hi = 1'b1; nb = 0; end
                end else begin
                    if (segq.size() > 0 && segq[0].lvl == 1'b1) begin
                        chk("seg_hi", run, segq[0].len);
                        void'(segq.pop_front());
                    end
                    if (dec) begin
                        if (first_hi) first_hi = 1'b0;
                        else begin
                            word = {word[30:0], (run > (BSD0 + BSD1) / 2) ? 1'b1 : 1'b0};
                            nb++;
                            if (nb == 32) begin
                                dec = 1'b0;
                                if (codeq.size() > 0) chk("code", word, codeq.pop_front());
                                else chk("code_extra", 1, 0);
                            end
                        end
                    end
                end
                chk("carrier", cerr, 0);
                cerr = 0;
                prev = signal_out;
                run = 1;
            end
            if (signal_out == 1'b0) begin
                if (ir_out !== (((run - 1) % CP) < CP / 2)) cerr++;
            end else if (ir_out !== 1'b0) cerr++;
        end
    end

    task automatic send(input logic [31:0] c, output int t1);
        @(negedge clk_in);
        chk("pre_idle", {28'd0, state_out}, 0);
        code_in = c; send_in = 1'b1;
        push_frame(c);
        @(posedge clk_in); #1;
        chk("acc_busy", busy_out, 1);
        chk("acc_sig", signal_out, 0);
        t1 = cyc;
        send_in = 1'b0;
        code_in = ~c;
    endtask

    task automatic wait_done(output int t);
        int g = 0;
        do begin @(negedge clk_in); g++; end while (!done_out && g < 3000);
        if (!done_out) chk("done_timeout", 0, 1);
        t = cyc;
    endtask

    task automatic wait_idle(output int t);
        int g = 0;
        do begin @(negedge clk_in); g++; end while (busy_out && g < 3000);
        if (busy_out) chk("idle_timeout", 0, 1);
        t = cyc;
    endtask

    initial begin
        int t1, td, ti, d0, g;
        repeat (5) @(negedge clk_in);
        chk("rst_vec", {28'd0, signal_out, ir_out, busy_out, done_out}, 32'b1000);
        chk("rst_state", {28'd0, state_out}, 0);
        rst_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            chk("idle_vec", {28'd0, signal_out, ir_out, busy_out, done_out}, 32'b1000);
        end

        // Timed frame: done 685 cycles after T+1, busy drops 20 later
        d0 = ndone;
        send(32'hA5A50F0F, t1);
        wait_done(td);
        chk("done_lat", td - t1, 685);
        @(negedge clk_in);
        chk("done_1cyc", done_out, 0);
        wait_idle(ti);
        chk("busy_lat", ti - t1, 705);
        chk("done_once", ndone - d0, 1);

        send(32'h00000000, t1); wait_done(td); wait_idle(ti);
        send(32'hFFFFFFFF, t1); wait_done(td); wait_idle(ti);

        // send_in held: mid-frame code change ignored, re-accept on busy drop
        @(negedge clk_in);
        code_in = 32'h13579BDF; send_in = 1'b1;
        push_frame(32'h13579BDF);
        @(posedge clk_in); #1;
        chk("held_acc", busy_out, 1);
        repeat (100) @(negedge clk_in);
        code_in = 32'hDEADBEEF;
        wait_idle(ti);
        code_in = 32'h0F1E2D3C;
        push_frame(32'h0F1E2D3C);
        @(posedge clk_in); #1;
        chk("held_reacc", busy_out, 1);
        send_in = 1'b0;
        wait_done(td); wait_idle(ti);

        // Asynchronous reset during BIT_S of bit 10
        send(32'h12345678, t1);
        g = 0;
        for (int n = 0; n < 11 && g < 3000; ) begin
            logic [3:0] ps = state_out;
            @(negedge clk_in); g++;
            if (state_out == 4'd4 && ps != 4'd4) n++;
        end
        chk("bit10_reached", {28'd0, state_out}, 4);
        d0 = ndone;
        #2 rst_in = 1'b0;
        #1;
        chk("arst_sig", signal_out, 1);
        chk("arst_ir", ir_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_state", {28'd0, state_out}, 0);
        segq.delete(); codeq.delete();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (30) @(negedge clk_in);
        chk("no_done_abort", ndone - d0, 0);
        send(32'hA5A50F0F, t1); wait_done(td); wait_idle(ti);

        repeat (10) @(negedge clk_in);
        chk("segq_empty", segq.size(), 0);
        chk("codeq_empty", codeq.size(), 0);
        chk("carrier_tail", cerr, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
